freelist_release_unit: RTL and testbench

- Writer side of the physical-register freelist FIFO.
- Collects the stale physical tags freed by up to RETIRE_WIDTH retiring instructions per cycle and holds them in a small staging queue.
- Drains the queue onto the freelist's single enqueue port, one tag per cycle, and back-pressures retirement when staging space runs low.

---
 rtl/freelist_release_unit.sv | 105 ++++++++++
 tb/tb_freelist_release_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/freelist_release_unit.sv
// Freelist writer: compacts freed retire tags into a staging ring, drains one/cycle.
// Optional sticky error output under FREELIST_RELEASE_ERR_CHECK_EN.
module freelist_release_unit #(
  parameter int RETIRE_WIDTH = 2,
  parameter int STAGE_DEPTH  = 8,
  parameter int TAG_WIDTH    = 6
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [RETIRE_WIDTH-1:0]           retire_valid,
  input  logic [RETIRE_WIDTH*TAG_WIDTH-1:0] retire_free_tag,
  output logic                              retire_ready,
  input  logic                              fl_full,
  output logic                              fl_enqueue,
  output logic [TAG_WIDTH-1:0]              fl_data,
  output logic [$clog2(STAGE_DEPTH+1)-1:0]  pending_count
`ifdef FREELIST_RELEASE_ERR_CHECK_EN
  ,
  output logic                              release_err
`endif
);

  localparam int PW = $clog2(STAGE_DEPTH);
  localparam int CW = $clog2(STAGE_DEPTH+1);
  localparam logic [CW-1:0] READY_MAX =
    CW'(STAGE_DEPTH - RETIRE_WIDTH);

  logic [TAG_WIDTH-1:0]    mem [STAGE_DEPTH];
  logic [PW-1:0]           head_ptr;
  logic [PW-1:0]           tail_ptr;
  logic [CW-1:0]           count;
  logic [CW-1:0]           count_nxt;
  logic [CW-1:0]           k;
  logic [CW-1:0]           k_eff;
  logic [RETIRE_WIDTH-1:0] nonzero;
  logic [RETIRE_WIDTH-1:0] accept;
  logic [PW-1:0]           wr_off [RETIRE_WIDTH];
  logic                    pop;

  // Prefix count of accepted slots gives each one its hole-free offset.
  always_comb begin
    k = '0;
    for (int i = 0; i < RETIRE_WIDTH; i++) begin
      nonzero[i] =
        retire_free_tag[i*TAG_WIDTH +: TAG_WIDTH] != '0;
      accept[i] = retire_valid[i] && nonzero[i];
      wr_off[i] = PW'(k);
      k = k + CW'(accept[i]);
    end
  end

  assign retire_ready  = count <= READY_MAX;
  assign k_eff         = retire_ready ? k : '0;
  assign fl_enqueue    = (count != '0) && !fl_full;
  assign pop           = fl_enqueue;
  assign fl_data       = (count != '0) ? mem[head_ptr] : '0;
  assign pending_count = count;
  assign count_nxt     = count + k_eff - CW'(pop);

  always_ff @(posedge clock) begin
    for (int i = 0; i < RETIRE_WIDTH; i++) begin
      if (retire_ready && accept[i]) begin
        mem[tail_ptr + wr_off[i]] <=
          retire_free_tag[i*TAG_WIDTH +: TAG_WIDTH];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      head_ptr <= head_ptr + PW'(pop);
      tail_ptr <= tail_ptr + PW'(k_eff);
      count    <= count_nxt;
    end
  end

`ifdef FREELIST_RELEASE_ERR_CHECK_EN
  logic stall_q;
  logic stall_now;
  logic err_now;

  // Head stuck behind a full freelist two cycles running means a double free.
  assign stall_now = fl_full && (count != '0);
  assign err_now   = ((|retire_valid) && !retire_ready)
                   || (|(retire_valid & ~nonzero))
                   || (stall_q && stall_now);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_q     <= 1'b0;
      release_err <= 1'b0;
    end else begin
      stall_q <= stall_now;
      if (err_now) begin
        release_err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_freelist_release_unit.sv
// Self-checking bench for freelist_release_unit: vector table, directed
// corner sequences and a queue-based reference model under random traffic.
module tb_freelist_release_unit;

  logic        clock;
  logic        reset;
  logic [1:0]  retire_valid;
  logic [11:0] retire_free_tag;
  logic        retire_ready;
  logic        fl_full;
  logic        fl_enqueue;
  logic [5:0]  fl_data;
  logic [3:0]  pending_count;
`ifdef FREELIST_RELEASE_ERR_CHECK_EN
  logic        release_err;
`endif

  freelist_release_unit #(
    .RETIRE_WIDTH(2),
    .STAGE_DEPTH(8),
    .TAG_WIDTH(6)
  ) dut (
    .clock(clock),
    .reset(reset),
    .retire_valid(retire_valid),
    .retire_free_tag(retire_free_tag),
    .retire_ready(retire_ready),
    .fl_full(fl_full),
    .fl_enqueue(fl_enqueue),
    .fl_data(fl_data),
    .pending_count(pending_count)
`ifdef FREELIST_RELEASE_ERR_CHECK_EN
    ,
    .release_err(release_err)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0] v;
    logic [5:0] t1;
    logic [5:0] t0;
    logic       f;
    logic       enq;
    logic [5:0] data;
    logic [3:0] pend;
    logic       rdy;
  } vec_t;

  vec_t tbl [21];
  int   vecs;
  int   errs;
  logic [5:0] q [$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v,
                       input logic [5:0] t1,
                       input logic [5:0] t0,
                       input logic f);
    @(negedge clock);
    retire_valid    = v;
    retire_free_tag = {t1, t0};
    fl_full         = f;
    #1;
  endtask

  // Reference: FIFO of staged tags; ready judged on occupancy at cycle start.
  task automatic step(input logic [1:0] v,
                      input logic [5:0] t1,
                      input logic [5:0] t0,
                      input logic f,
                      input string nm);
    int   sz;
    logic e_rdy;
    logic e_enq;
    logic [5:0] tg [2];
    sz    = q.size();
    e_rdy = (8 - sz) >= 2;
    e_enq = (sz != 0) && !f;
    drive(v, t1, t0, f);
    chk({nm, ".enq"}, 32'(fl_enqueue), 32'(e_enq));
    chk({nm, ".data"}, 32'(fl_data),
        (sz != 0) ? 32'(q[0]) : 32'd0);
    chk({nm, ".pend"}, 32'(pending_count), 32'(sz));
    chk({nm, ".rdy"}, 32'(retire_ready), 32'(e_rdy));
    tg[0] = t0;
    tg[1] = t1;
    if (e_enq) void'(q.pop_front());
    if (e_rdy) begin
      for (int i = 0; i < 2; i++) begin
        if (v[i] && tg[i] != 6'd0) q.push_back(tg[i]);
      end
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, ".enq"}, 32'(fl_enqueue), 32'd0);
    chk({nm, ".rdy"}, 32'(retire_ready), 32'd1);
    chk({nm, ".pend"}, 32'(pending_count), 32'd0);
    chk({nm, ".data"}, 32'(fl_data), 32'd0);
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    reset = 1'b0;
    retire_valid = '0;
    retire_free_tag = '0;
    fl_full = 1'b0;

    // v, t1, t0, f | enq, data, pend, rdy
    tbl[0]  = '{2'b11,  5,  9, 0, 0,  0, 0, 1};
    tbl[1]  = '{2'b00,  0,  0, 0, 1,  9, 2, 1};
    tbl[2]  = '{2'b00,  0,  0, 0, 1,  5, 1, 1};
    tbl[3]  = '{2'b00,  0,  0, 0, 0,  0, 0, 1};
    tbl[4]  = '{2'b10, 12,  0, 0, 0,  0, 0, 1};
    tbl[5]  = '{2'b00,  0,  0, 0, 1, 12, 1, 1};
    tbl[6]  = '{2'b00,  0,  0, 0, 0,  0, 0, 1};
    tbl[7]  = '{2'b11,  9,  8, 1, 0,  0, 0, 1};
    tbl[8]  = '{2'b11, 11, 10, 1, 0,  8, 2, 1};
    tbl[9]  = '{2'b11, 13, 12, 1, 0,  8, 4, 1};
    tbl[10] = '{2'b11, 15, 14, 1, 0,  8, 6, 1};
    tbl[11] = '{2'b11, 21, 20, 1, 0,  8, 8, 0};
    tbl[12] = '{2'b00,  0,  0, 0, 1,  8, 8, 0};
    tbl[13] = '{2'b00,  0,  0, 0, 1,  9, 7, 0};
    tbl[14] = '{2'b00,  0,  0, 0, 1, 10, 6, 1};
    tbl[15] = '{2'b00,  0,  0, 0, 1, 11, 5, 1};
    tbl[16] = '{2'b00,  0,  0, 0, 1, 12, 4, 1};
    tbl[17] = '{2'b00,  0,  0, 0, 1, 13, 3, 1};
    tbl[18] = '{2'b00,  0,  0, 0, 1, 14, 2, 1};
    tbl[19] = '{2'b00,  0,  0, 0, 1, 15, 1, 1};
    tbl[20] = '{2'b00,  0,  0, 0, 0,  0, 0, 1};

    repeat (2) @(negedge clock);
    #1;
    chk_reset_vals("reset");
`ifdef FREELIST_RELEASE_ERR_CHECK_EN
    chk("reset.err", 32'(release_err), 32'd0);
`endif
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].v, tbl[i].t1, tbl[i].t0, tbl[i].f);
      chk($sformatf("tbl%0d.enq", i),
          32'(fl_enqueue), 32'(tbl[i].enq));
      chk($sformatf("tbl%0d.data", i),
          32'(fl_data), 32'(tbl[i].data));
      chk($sformatf("tbl%0d.pend", i),
          32'(pending_count), 32'(tbl[i].pend));
      chk($sformatf("tbl%0d.rdy", i),
          32'(retire_ready), 32'(tbl[i].rdy));
    end

    // Steady single-tag stream wraps the pointers several times.
    q.delete();
    for (int i = 0; i < 20; i++) begin
      step(2'b01, 6'd0, 6'(i + 30), 1'b0,
           $sformatf("steady%0d", i));
    end
    step(2'b00, 0, 0, 0, "steady_tail");
    step(2'b00, 0, 0, 0, "steady_empty");

    // Build count=5, then async reset in mid-cycle.
    step(2'b11, 6'd1, 6'd2, 1'b1, "pre_rst0");
    step(2'b11, 6'd3, 6'd4, 1'b1, "pre_rst1");
    step(2'b11, 6'd5, 6'd6, 1'b1, "pre_rst2");
    step(2'b00, 6'd0, 6'd0, 1'b0, "pre_rst3");
    drive(2'b00, 0, 0, 0);
    chk("pre_rst.pend", 32'(pending_count), 32'd5);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    q.delete();
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(2'b00, 0, 0, 0, $sformatf("post_rst%0d", i));
    end

    // Random traffic; retirement only offers groups when ready.
    for (int i = 0; i < 600; i++) begin
      logic [1:0] v;
      logic f;
      f = $urandom_range(0, 9) < 4;
      v = ((8 - q.size()) >= 2) ? 2'($urandom_range(0, 3)) : 2'b00;
      step(v, 6'($urandom_range(0, 63)),
           6'($urandom_range(0, 63)), f,
           $sformatf("rnd%0d", i));
    end
    for (int i = 0; i < 10; i++) begin
      step(2'b00, 0, 0, 0, $sformatf("flush%0d", i));
    end

`ifdef FREELIST_RELEASE_ERR_CHECK_EN
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("err_rst", 32'(release_err), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    drive(2'b01, 6'd0, 6'd0, 1'b0);
    chk("err_pre", 32'(release_err), 32'd0);
    for (int i = 0; i < 4; i++) begin
      drive(2'b00, 0, 0, 0);
      chk($sformatf("err_sticky%0d", i),
          32'(release_err), 32'd1);
    end
    reset = 1'b0;
    #1;
    chk("err_clr", 32'(release_err), 32'd0);
    reset = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
